mc_controller: RTL and testbench

- Multi-cycle MIPS main controller FSM that replaces the single-cycle decoder in the multi-cycle datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with a variable-latency memory (mem_req/mem_ready) and raises a timeout error when memory never responds.
- Parametrised for an optional extended instruction set and the memory timeout bound.

---
 rtl/mc_controller_if.sv | 34 +++
 rtl/mc_controller.sv | 186 ++++++++++++++++++
 tb/tb_mc_controller.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle controller and its datapath/memory.
// master = controller side, slave = datapath/memory side.
interface mc_controller_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       Zero;
   logic       mem_ready;
   logic       mem_req;
   logic       IRWr;
   logic       PCWr;
   logic [1:0] NPCSel;
   logic       RFWr;
   logic [1:0] WDSel;
   logic [1:0] DstSel;
   logic       DMWr;
   logic [1:0] ALUOp;
   logic       ALUBSel;
   logic [1:0] EXTOp;
   logic       illegal;
   logic       mem_err;
   logic [2:0] state;

   modport master (
      input  opcode, funct, Zero, mem_ready,
      output mem_req, IRWr, PCWr, NPCSel, RFWr, WDSel, DstSel, DMWr,
             ALUOp, ALUBSel, EXTOp, illegal, mem_err, state
   );

   modport slave (
      output opcode, funct, Zero, mem_ready,
      input  mem_req, IRWr, PCWr, NPCSel, RFWr, WDSel, DstSel, DMWr,
             ALUOp, ALUBSel, EXTOp, illegal, mem_err, state
   );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// variable-latency memory handshake and a sticky timeout error.
module mc_controller #(
   parameter logic EN_EXT      = 1'b1,
   parameter int   MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   mc_controller_if.master  bus
);
   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;

   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   logic [2:0] state_q, state_n;
   logic [7:0] wait_cnt;
   logic       mem_err_q;
   logic       cnt_inc, set_err, timeout;

   // Decode
   logic is_r, is_addu, is_subu, is_slt, is_jr;
   logic is_ori, is_lw, is_sw, is_beq, is_lui, is_jal, is_addiu, is_j, legal;

   assign is_r     = (bus.opcode == 6'b000000);
   assign is_addu  = is_r && (bus.funct == 6'b100001);
   assign is_subu  = is_r && (bus.funct == 6'b100011);
   assign is_jr    = is_r && (bus.funct == 6'b001000);
   assign is_slt   = EN_EXT && is_r && (bus.funct == 6'b101010);
   assign is_ori   = (bus.opcode == 6'b001101);
   assign is_lw    = (bus.opcode == 6'b100011);
   assign is_sw    = (bus.opcode == 6'b101011);
   assign is_beq   = (bus.opcode == 6'b000100);
   assign is_lui   = (bus.opcode == 6'b001111);
   assign is_jal   = (bus.opcode == 6'b000011);
   assign is_addiu = EN_EXT && (bus.opcode == 6'b001001);
   assign is_j     = EN_EXT && (bus.opcode == 6'b000010);
   assign legal    = is_addu | is_subu | is_slt | is_jr | is_ori | is_lw | is_sw |
                     is_beq | is_lui | is_jal | is_addiu | is_j;

   assign timeout = (wait_cnt == TO_LAST);

   // Unqualified control values, before the reset gate
   logic       mem_req, irwr, pcwr, rfwr, dmwr, alubsel, illegal;
   logic [1:0] npcsel, wdsel, dstsel, aluop, extop;

   // Memory handshake: mem_req stays high while waiting; a request completes
   // in the cycle mem_ready is sampled high, and any side effect (IRWr, PCWr,
   // DMWr) is asserted only in that completing cycle.
   always_comb begin
      state_n = state_q;
      cnt_inc = 1'b0;
      set_err = 1'b0;
      mem_req = 1'b0;
      irwr    = 1'b0;
      pcwr    = 1'b0;
      npcsel  = 2'd0;
      rfwr    = 1'b0;
      wdsel   = 2'd0;
      dstsel  = 2'd0;
      dmwr    = 1'b0;
      aluop   = 2'd0;
      alubsel = 1'b0;
      extop   = 2'd0;
      illegal = 1'b0;

      if (state_q == EXEC || state_q == MEM || state_q == WB) begin
         if (is_subu || is_beq) aluop = 2'd1;
         else if (is_slt)       aluop = 2'd3;
         else if (is_ori)       aluop = 2'd2;
         if (is_ori) alubsel = 1'b1;
         if (is_lw || is_sw || is_addiu) begin
            alubsel = 1'b1;
            extop   = 2'd1;
         end
         if (is_lui) extop = 2'd2;
      end

      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               irwr    = 1'b1;
               pcwr    = 1'b1;
               state_n = DECODE;
            end else if (timeout) begin
               set_err = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DECODE: begin
            state_n = FETCH;
            if (!legal) begin
               illegal = 1'b1;
            end else if (is_jal) begin
               pcwr   = 1'b1;
               npcsel = 2'd2;
               rfwr   = 1'b1;
               dstsel = 2'd2;
               wdsel  = 2'd3;
            end else if (is_jr) begin
               pcwr   = 1'b1;
               npcsel = 2'd3;
            end else if (is_j) begin
               pcwr   = 1'b1;
               npcsel = 2'd2;
            end else begin
               state_n = EXEC;
            end
         end
         EXEC: begin
            if (is_beq) begin
               pcwr    = bus.Zero;
               npcsel  = 2'd1;
               state_n = FETCH;
            end else if (is_lw || is_sw) begin
               state_n = MEM;
            end else begin
               state_n = WB;
            end
         end
         MEM: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               dmwr    = is_sw;
               state_n = is_sw ? FETCH : WB;
            end else if (timeout) begin
               set_err = 1'b1;
               state_n = FETCH;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         WB: begin
            rfwr    = 1'b1;
            state_n = FETCH;
            if (is_lw) begin
               dstsel = 2'd1;
               wdsel  = 2'd1;
            end else if (is_lui) begin
               dstsel = 2'd1;
               wdsel  = 2'd2;
            end else if (is_ori || is_addiu) begin
               dstsel = 2'd1;
            end
         end
         default: state_n = FETCH;
      endcase
   end

   // Counter clears whenever it is not explicitly advancing, which covers
   // every state change and the timeout return.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         wait_cnt  <= 8'd0;
         mem_err_q <= 1'b0;
      end else begin
         state_q  <= state_n;
         wait_cnt <= cnt_inc ? wait_cnt + 8'd1 : 8'd0;
         if (set_err) mem_err_q <= 1'b1;
      end
   end

   // Reset silences every output so an aborted instruction has no side effect
   always_comb begin
      bus.mem_req = !reset && mem_req;
      bus.IRWr    = !reset && irwr;
      bus.PCWr    = !reset && pcwr;
      bus.NPCSel  = reset ? 2'd0 : npcsel;
      bus.RFWr    = !reset && rfwr;
      bus.WDSel   = reset ? 2'd0 : wdsel;
      bus.DstSel  = reset ? 2'd0 : dstsel;
      bus.DMWr    = !reset && dmwr;
      bus.ALUOp   = reset ? 2'd0 : aluop;
      bus.ALUBSel = !reset && alubsel;
      bus.EXTOp   = reset ? 2'd0 : extop;
      bus.illegal = !reset && illegal;
      bus.mem_err = !reset && mem_err_q;
      bus.state   = reset ? 3'd0 : state_q;
   end
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: cycle vectors on a default-parameter instance plus
// hand sequences on an EN_EXT=0, MEM_TIMEOUT=4 instance.
module tb_mc_controller;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_ADI = 6'b001001;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       irwr;
    logic       pcwr;
    logic [1:0] npc;
    logic       rfwr;
    logic [1:0] wd;
    logic [1:0] dst;
    logic       dmwr;
    logic [1:0] alu;
    logic       bsel;
    logic [1:0] ext;
    logic       ill;
    logic       merr;
  } ctl_t;

  typedef struct {
    string      nm;
    logic       r;
    logic [5:0] o;
    logic [5:0] f;
    logic       z;
    logic       rd;
    ctl_t       e;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  vec_t vecs[$];

  mc_controller_if ia ();
  mc_controller_if ib ();
  assign ia.opcode = opcode;
  assign ia.funct = funct;
  assign ia.Zero = zero;
  assign ia.mem_ready = mem_ready;
  assign ib.opcode = opcode;
  assign ib.funct = funct;
  assign ib.Zero = zero;
  assign ib.mem_ready = mem_ready;

  mc_controller dut_a (.clk(clk), .reset(reset), .bus(ia));
  mc_controller #(.EN_EXT(1'b0), .MEM_TIMEOUT(4)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  ctl_t obs_a, obs_b;
  always_comb begin
    obs_a = '{ia.state, ia.mem_req, ia.IRWr, ia.PCWr, ia.NPCSel, ia.RFWr, ia.WDSel,
              ia.DstSel, ia.DMWr, ia.ALUOp, ia.ALUBSel, ia.EXTOp, ia.illegal, ia.mem_err};
    obs_b = '{ib.state, ib.mem_req, ib.IRWr, ib.PCWr, ib.NPCSel, ib.RFWr, ib.WDSel,
              ib.DstSel, ib.DMWr, ib.ALUOp, ib.ALUBSel, ib.EXTOp, ib.illegal, ib.mem_err};
  end

  function automatic ctl_t mk(int st, int req, int irwr, int pcwr, int npc, int rfwr,
                              int wd, int dst, int dmwr, int alu, int bsel, int ext,
                              int ill, int merr);
    ctl_t c;
    c.st = 3'(st); c.req = 1'(req); c.irwr = 1'(irwr); c.pcwr = 1'(pcwr);
    c.npc = 2'(npc); c.rfwr = 1'(rfwr); c.wd = 2'(wd); c.dst = 2'(dst);
    c.dmwr = 1'(dmwr); c.alu = 2'(alu); c.bsel = 1'(bsel); c.ext = 2'(ext);
    c.ill = 1'(ill); c.merr = 1'(merr);
    return c;
  endfunction

  function automatic ctl_t fhit(int merr);
    return mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, merr);
  endfunction

  function automatic ctl_t fwait(int merr);
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, merr);
  endfunction

  function automatic ctl_t idle(int st);
    return mk(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // driver + check: drive on the falling edge, compare 1 ns later
  task automatic step(string nm, logic r, logic [5:0] o, logic [5:0] f, logic zz,
                      logic rd, logic use_b, ctl_t e);
    ctl_t got;
    @(negedge clk);
    reset = r; opcode = o; funct = f; zero = zz; mem_ready = rd;
    #1;
    got = use_b ? obs_b : obs_a;
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s (dut %s): got %h expected %h", nm, use_b ? "b" : "a", got, e);
    end
  endtask

  task automatic add(string nm, logic r, logic [5:0] o, logic [5:0] f, logic zz,
                     logic rd, ctl_t e);
    vec_t v;
    v.nm = nm; v.r = r; v.o = o; v.f = f; v.z = zz; v.rd = rd; v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    // reset, then R/I-type paths through WB
    add("rst0", 1, OP_R, F_ADDU, 0, 1, idle(0));
    add("rst1", 1, OP_R, F_ADDU, 0, 1, idle(0));
    add("addu_f", 0, OP_R, F_ADDU, 0, 1, fhit(0));
    add("addu_d", 0, OP_R, F_ADDU, 0, 1, idle(1));
    add("addu_e", 0, OP_R, F_ADDU, 0, 1, idle(2));
    add("addu_w", 0, OP_R, F_ADDU, 0, 1, mk(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("subu_f", 0, OP_R, F_SUBU, 0, 1, fhit(0));
    add("subu_d", 0, OP_R, F_SUBU, 0, 1, idle(1));
    add("subu_e", 0, OP_R, F_SUBU, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add("subu_w", 0, OP_R, F_SUBU, 0, 1, mk(4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    add("ori_f", 0, OP_ORI, 0, 0, 1, fhit(0));
    add("ori_d", 0, OP_ORI, 0, 0, 1, idle(1));
    add("ori_e", 0, OP_ORI, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    add("ori_w", 0, OP_ORI, 0, 0, 1, mk(4, 0, 0, 0, 0, 1, 0, 1, 0, 2, 1, 0, 0, 0));
    add("lui_f", 0, OP_LUI, 0, 0, 1, fhit(0));
    add("lui_d", 0, OP_LUI, 0, 0, 1, idle(1));
    add("lui_e", 0, OP_LUI, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    add("lui_w", 0, OP_LUI, 0, 0, 1, mk(4, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 2, 0, 0));
    add("addiu_f", 0, OP_ADI, 0, 0, 1, fhit(0));
    add("addiu_d", 0, OP_ADI, 0, 0, 1, idle(1));
    add("addiu_e", 0, OP_ADI, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add("addiu_w", 0, OP_ADI, 0, 0, 1, mk(4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0));
    add("slt_f", 0, OP_R, F_SLT, 0, 1, fhit(0));
    add("slt_d", 0, OP_R, F_SLT, 0, 1, idle(1));
    add("slt_e", 0, OP_R, F_SLT, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
    add("slt_w", 0, OP_R, F_SLT, 0, 1, mk(4, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0));
    // lw with data ready delayed 3 cycles
    add("lw_f", 0, OP_LW, 0, 0, 1, fhit(0));
    add("lw_d", 0, OP_LW, 0, 0, 1, idle(1));
    add("lw_e", 0, OP_LW, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      add("lw_mwait", 0, OP_LW, 0, 0, 0, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add("lw_mrdy", 0, OP_LW, 0, 0, 1, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add("lw_w", 0, OP_LW, 0, 0, 1, mk(4, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0));
    // branches and jumps
    add("beq1_f", 0, OP_BEQ, 0, 1, 1, fhit(0));
    add("beq1_d", 0, OP_BEQ, 0, 1, 1, idle(1));
    add("beq1_e", 0, OP_BEQ, 0, 1, 1, mk(2, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add("beq0_f", 0, OP_BEQ, 0, 0, 1, fhit(0));
    add("beq0_d", 0, OP_BEQ, 0, 0, 1, idle(1));
    add("beq0_e", 0, OP_BEQ, 0, 0, 1, mk(2, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add("jal_f", 0, OP_JAL, 0, 0, 1, fhit(0));
    add("jal_d", 0, OP_JAL, 0, 0, 1, mk(1, 0, 0, 1, 2, 1, 3, 2, 0, 0, 0, 0, 0, 0));
    add("jr_f", 0, OP_R, F_JR, 0, 1, fhit(0));
    add("jr_d", 0, OP_R, F_JR, 0, 1, mk(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("j_f", 0, OP_J, 0, 0, 1, fhit(0));
    add("j_d", 0, OP_J, 0, 0, 1, mk(1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // sw with immediate ready, illegal opcode, fetch wait
    add("sw_f", 0, OP_SW, 0, 0, 1, fhit(0));
    add("sw_d", 0, OP_SW, 0, 0, 1, idle(1));
    add("sw_e", 0, OP_SW, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add("sw_m", 0, OP_SW, 0, 0, 1, mk(3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    add("bad_f", 0, OP_BAD, 0, 0, 1, fhit(0));
    add("bad_d", 0, OP_BAD, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    add("fwait", 0, OP_R, F_ADDU, 0, 0, fwait(0));
    // reset in MEM aborts lw with no strobe
    add("abort_f", 0, OP_LW, 0, 0, 1, fhit(0));
    add("abort_d", 0, OP_LW, 0, 0, 1, idle(1));
    add("abort_e", 0, OP_LW, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add("abort_rst", 1, OP_LW, 0, 0, 1, idle(0));
    add("abort_after", 0, OP_LW, 0, 0, 1, fhit(0));

    foreach (vecs[i])
      step(vecs[i].nm, vecs[i].r, vecs[i].o, vecs[i].f, vecs[i].z, vecs[i].rd, 1'b0, vecs[i].e);

    // EN_EXT=0: slt decodes as illegal, one-cycle pulse, no RFWr
    step("b_rst", 1, OP_R, F_SLT, 0, 1, 1'b1, idle(0));
    step("b_slt_f", 0, OP_R, F_SLT, 0, 1, 1'b1, fhit(0));
    step("b_slt_d", 0, OP_R, F_SLT, 0, 1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("b_slt_after", 0, OP_R, F_SLT, 0, 0, 1'b1, fwait(0));

    // sw timeout in MEM after 4 waiting cycles; mem_err is sticky
    step("b_to_rst", 1, OP_SW, 0, 0, 1, 1'b1, idle(0));
    step("b_to_f", 0, OP_SW, 0, 0, 1, 1'b1, fhit(0));
    step("b_to_d", 0, OP_SW, 0, 0, 0, 1'b1, idle(1));
    step("b_to_e", 0, OP_SW, 0, 0, 0, 1'b1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      step("b_to_mwait", 0, OP_SW, 0, 0, 0, 1'b1, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    step("b_to_back", 0, OP_SW, 0, 0, 0, 1'b1, fwait(1));
    step("b_to_sticky_f", 0, OP_SW, 0, 0, 1, 1'b1, fhit(1));
    step("b_to_sticky_d", 0, OP_SW, 0, 0, 1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("b_to_clr_rst", 1, OP_SW, 0, 0, 0, 1'b1, idle(0));
    step("b_to_clr", 0, OP_SW, 0, 0, 0, 1'b1, fwait(0));

    // ready on the last allowed MEM cycle wins over the timeout
    step("b_rdy_rst", 1, OP_SW, 0, 0, 1, 1'b1, idle(0));
    step("b_rdy_f", 0, OP_SW, 0, 0, 1, 1'b1, fhit(0));
    step("b_rdy_d", 0, OP_SW, 0, 0, 0, 1'b1, idle(1));
    step("b_rdy_e", 0, OP_SW, 0, 0, 0, 1'b1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      step("b_rdy_mwait", 0, OP_SW, 0, 0, 0, 1'b1, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    step("b_rdy_m4", 0, OP_SW, 0, 0, 1, 1'b1, mk(3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    step("b_rdy_back", 0, OP_SW, 0, 0, 0, 1'b1, fwait(0));

    // instruction fetch timeout stays in FETCH and sets mem_err
    step("b_fto_rst", 1, OP_R, F_ADDU, 0, 0, 1'b1, idle(0));
    for (int i = 0; i < 4; i++)
      step("b_fto_wait", 0, OP_R, F_ADDU, 0, 0, 1'b1, fwait(0));
    step("b_fto_err", 0, OP_R, F_ADDU, 0, 0, 1'b1, fwait(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
